// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Sequential instruction fetch front end. Owns the PC, issues word fetches to
//   instruction memory, buffers returned words in order with their PCs and hands
//   them to decode over valid/ready. A redirect flushes the buffer, restarts at
//   the new PC and discards every response still in flight.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/gnt          fetch request channel (addr held while req & !gnt)
//   imem_rvalid/rdata          in-order read responses, latency >= 1
//   redirect_valid/pc          one-cycle flush + restart pulse
//   instr_valid/ready/o/pc     decode handshake
//   misalign_err               sticky misaligned-redirect flag
//
// Config macro: FETCH_MISALIGN_CHK_EN
//   defined   : redirect_pc[1:0] != 0 sets misalign_err and halts fetching until
//               the next aligned redirect.
//   undefined : misalign_err is constant 0, redirect_pc[1:0] is ignored.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc,
    output logic            misalign_err
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t                         state;
    logic [XLEN-1:0]                pc;
    logic [CW-1:0]                  out_cnt, drop_cnt, buf_cnt;
    logic [AW-1:0]                  wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [BUF_DEPTH-1:0][XLEN-1:0] buf_data, buf_pc, tag_pc;
    logic [XLEN-1:0]                hold_data, hold_pc;
    logic                           halt;

    logic            fire, keep, pop, halt_nxt;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   out_nxt, buf_nxt;
    logic [CW:0]     occ, occ_nxt, limit;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target   = redirect_pc;
    assign halt_nxt = redirect_valid ? (redirect_pc[1:0] != 2'b00) : halt;
`else
    assign target   = {redirect_pc[XLEN-1:2], 2'b00};
    assign halt_nxt = 1'b0;
`endif

    always_comb begin
        pop     = instr_valid & instr_ready;
        fire    = imem_req & imem_gnt;
        // A response in the redirect cycle belongs to the old path.
        keep    = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
        out_nxt = out_cnt + CW'(fire) - CW'(imem_rvalid);
        buf_nxt = redirect_valid ? '0 : (buf_cnt + CW'(keep) - CW'(pop));
        occ     = {1'b0, buf_cnt} + {1'b0, out_cnt};
        occ_nxt = {1'b0, buf_nxt} + {1'b0, out_nxt};
        // A pop this cycle frees a slot before any new response can land
        // (latency >= 1), so it counts as credit. Occupancy only falls without
        // a grant, so a request once raised stays raised until granted.
        limit   = (CW+1)'(BUF_DEPTH) + (CW+1)'(pop);
    end

    assign imem_req     = (state != IDLE) && !halt && (occ < limit);
    assign imem_addr    = pc;
    assign instr_valid  = (buf_cnt != '0);
    assign instr_o      = instr_valid ? buf_data[rd_ptr] : hold_data;
    assign instr_pc     = instr_valid ? buf_pc[rd_ptr]   : hold_pc;
    assign misalign_err = halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            out_cnt   <= '0;
            drop_cnt  <= '0;
            buf_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_wr    <= '0;
            tag_rd    <= '0;
            buf_data  <= '0;
            buf_pc    <= '0;
            tag_pc    <= '0;
            hold_data <= '0;
            hold_pc   <= '0;
            halt      <= 1'b0;
        end else begin
            state   <= (halt_nxt || occ_nxt >= (CW+1)'(BUF_DEPTH)) ? STALL : FETCH;
            halt    <= halt_nxt;
            out_cnt <= out_nxt;
            buf_cnt <= buf_nxt;
            // Keep the last presented word visible once the buffer drains.
            if (buf_cnt != '0) begin
                hold_data <= buf_data[rd_ptr];
                hold_pc   <= buf_pc[rd_ptr];
            end
            if (redirect_valid) begin
                // Everything still in flight after this cycle is wrong-path.
                pc       <= target;
                drop_cnt <= out_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (fire) begin
                    pc             <= pc + XLEN'(4);
                    tag_pc[tag_wr] <= pc;
                    tag_wr         <= tag_wr + AW'(1);
                end
                if (imem_rvalid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                if (keep) begin
                    buf_data[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]   <= tag_pc[tag_rd];
                    wr_ptr           <= wr_ptr + AW'(1);
                    tag_rd           <= tag_rd + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
endmodule
